// File: rtl/hsi_req_arbiter.sv
// ---------------------------------------------------------------------------
// hsi_req_arbiter
//
// Purpose:
//   Shares one HSI request/response channel pair between NREQ requesters.
//   A round-robin winner is chosen in IDLE. Its request beats are forwarded
//   (one beat for read/RWM/invalidate, RESP_BEATS beats for write-out), then
//   the expected response beats are routed back to it (RESP_BEATS for
//   read/RWM, one for invalidate/write-out). A response exception ends the
//   transaction early.
//
// Configuration:
//   HSI_ARB_TIMEOUT_EN - when defined, a 10-bit response watchdog emits one
//                        synthetic exception beat after 1023 silent cycles
//                        in RESP. When undefined, RESP waits indefinitely.
//
// Ports:
//   host_clk_i        clock
//   host_rst_ni       synchronous active-low reset
//   req_vld_i         per-requester request valid            [NREQ]
//   req_op_i          per-requester opcode                   [2*NREQ]
//   req_cl_i          per-requester cache line address       [23*NREQ]
//   req_data_i        per-requester write-out beat data      [64*NREQ]
//   req_rdy_o         accepted-beat pulse to the owner       [NREQ]
//   cache_req_*_o     shared HSI request channel (vld/op/cl/data)
//   emc_busy_i        request channel backpressure
//   cache_resp_*_i    HSI response channel (vld/data/exc/fwd)
//   resp_*_o          routed response (vld[NREQ]/data/exc/fwd)
//   busy_o            high whenever a transaction is in flight
//   grant_o           one-hot current owner                  [NREQ]
// ---------------------------------------------------------------------------
module hsi_req_arbiter #(
    parameter int NREQ       = 2,
    parameter int RESP_BEATS = 16
) (
    input  logic                 host_clk_i,
    input  logic                 host_rst_ni,
    input  logic [NREQ-1:0]      req_vld_i,
    input  logic [2*NREQ-1:0]    req_op_i,
    input  logic [23*NREQ-1:0]   req_cl_i,
    input  logic [64*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_rdy_o,
    output logic                 cache_req_vld_o,
    output logic [1:0]           cache_req_op_o,
    output logic [22:0]          cache_req_cl_o,
    output logic [63:0]          cache_req_data_o,
    input  logic                 emc_busy_i,
    input  logic                 cache_resp_vld_i,
    input  logic [63:0]          cache_resp_data_i,
    input  logic                 cache_resp_exc_i,
    input  logic                 cache_resp_fwd_i,
    output logic [NREQ-1:0]      resp_vld_o,
    output logic [63:0]          resp_data_o,
    output logic                 resp_exc_o,
    output logic                 resp_fwd_o,
    output logic                 busy_o,
    output logic [NREQ-1:0]      grant_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (RESP_BEATS > 2) ? $clog2(RESP_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RESP_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [PW-1:0]     r_grantIdx;
    logic [PW-1:0]     r_rrPtr;
    logic [1:0]        r_op;
    logic [22:0]       r_cl;
    logic [BW-1:0]     r_reqBeat;
    logic [BW-1:0]     r_respBeat;
`ifdef HSI_ARB_TIMEOUT_EN
    logic [9:0]        r_wdog;
`endif

    logic [PW-1:0]     w_winner;
    logic [PW-1:0]     w_nextPtr;
    logic [NREQ-1:0]   w_winOneHot;
    logic [1:0]        w_winOp;
    logic [22:0]       w_winCl;
    logic [63:0]       w_reqData;
    logic              w_anyReq;
    logic              w_xfer;
    logic              w_reqLast;
    logic              w_respLast;
    logic              w_respBeat;
    logic              w_timeout;

    // Round-robin pick: scanning from the highest offset down lets the
    // requester closest to r_rrPtr overwrite all others.
    always_comb begin
        w_winner = '0;
        w_winOp  = '0;
        w_winCl  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_rrPtr) + k) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if ((j == idx) && req_vld_i[j]) begin
                    w_winner = PW'(j);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_winOp = req_op_i[2*i +: 2];
                w_winCl = req_cl_i[23*i +: 23];
            end
        end
    end

    // Write-out data changes every beat, so it is muxed live from the owner
    // rather than latched at grant time like op and cl.
    always_comb begin
        w_reqData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grantIdx == PW'(i)) begin
                w_reqData = req_data_i[64*i +: 64];
            end
        end
    end

    assign w_anyReq    = |req_vld_i;
    assign w_nextPtr   = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);
    assign w_winOneHot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_xfer      = (r_state == REQ) && !emc_busy_i;
    assign w_reqLast   = (r_op == 2'b11) ? (r_reqBeat == LAST_BEAT) : 1'b1;
    assign w_respLast  = (r_op[1] == 1'b0) ? (r_respBeat == LAST_BEAT) : 1'b1;
    assign w_respBeat  = (r_state == RESP) && cache_resp_vld_i;

    // A real response beat in the same cycle always wins over the
    // synthetic timeout beat.
`ifdef HSI_ARB_TIMEOUT_EN
    assign w_timeout = (r_state == RESP) && !cache_resp_vld_i && (r_wdog == 10'd1023);
`else
    assign w_timeout = 1'b0;
`endif

    assign cache_req_vld_o  = (r_state == REQ);
    assign cache_req_op_o   = r_op;
    assign cache_req_cl_o   = r_cl;
    assign cache_req_data_o = w_reqData;
    assign req_rdy_o        = w_xfer ? r_grant : '0;
    assign resp_vld_o       = (w_respBeat || w_timeout) ? r_grant : '0;
    assign resp_data_o      = w_timeout ? 64'd0 : cache_resp_data_i;
    assign resp_exc_o       = w_timeout | cache_resp_exc_i;
    assign resp_fwd_o       = w_timeout ? 1'b0 : cache_resp_fwd_i;
    assign busy_o           = (r_state != IDLE);
    assign grant_o          = r_grant;

    // Transaction FSM. Grant is registered in IDLE, so every transaction is
    // preceded by at least one IDLE cycle.
    always_ff @(posedge host_clk_i) begin
        if (!host_rst_ni) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_rrPtr    <= '0;
            r_op       <= '0;
            r_cl       <= '0;
            r_reqBeat  <= '0;
            r_respBeat <= '0;
`ifdef HSI_ARB_TIMEOUT_EN
            r_wdog     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant    <= w_winOneHot;
                        r_grantIdx <= w_winner;
                        r_op       <= w_winOp;
                        r_cl       <= w_winCl;
                        r_rrPtr    <= w_nextPtr;
                        r_reqBeat  <= '0;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (w_xfer) begin
                        if (w_reqLast) begin
                            r_respBeat <= '0;
`ifdef HSI_ARB_TIMEOUT_EN
                            r_wdog     <= '0;
`endif
                            r_state    <= RESP;
                        end else begin
                            r_reqBeat <= r_reqBeat + BW'(1);
                        end
                    end
                end
                RESP: begin
                    if (w_respBeat) begin
`ifdef HSI_ARB_TIMEOUT_EN
                        r_wdog <= '0;
`endif
                        if (cache_resp_exc_i || w_respLast) begin
                            r_grant <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_respBeat <= r_respBeat + BW'(1);
                        end
                    end
`ifdef HSI_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 10'd1;
                    end
`endif
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsi_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hsi_req_arbiter
//
// Drives directed scenarios with randomized data, response gaps and stray
// response beats, and compares every cycle against a transaction-level
// model (owner, beats remaining, round-robin pointer). Inputs are driven on
// the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_hsi_req_arbiter;

    localparam int NREQ       = 2;
    localparam int RESP_BEATS = 16;

    logic                 host_clk_i = 1'b0;
    logic                 host_rst_ni;
    logic [NREQ-1:0]      req_vld_i;
    logic [2*NREQ-1:0]    req_op_i;
    logic [23*NREQ-1:0]   req_cl_i;
    logic [64*NREQ-1:0]   req_data_i;
    logic [NREQ-1:0]      req_rdy_o;
    logic                 cache_req_vld_o;
    logic [1:0]           cache_req_op_o;
    logic [22:0]          cache_req_cl_o;
    logic [63:0]          cache_req_data_o;
    logic                 emc_busy_i;
    logic                 cache_resp_vld_i;
    logic [63:0]          cache_resp_data_i;
    logic                 cache_resp_exc_i;
    logic                 cache_resp_fwd_i;
    logic [NREQ-1:0]      resp_vld_o;
    logic [63:0]          resp_data_o;
    logic                 resp_exc_o;
    logic                 resp_fwd_o;
    logic                 busy_o;
    logic [NREQ-1:0]      grant_o;

    always #5 host_clk_i = ~host_clk_i;

    hsi_req_arbiter #(.NREQ(NREQ), .RESP_BEATS(RESP_BEATS)) dut (
        .host_clk_i        (host_clk_i),
        .host_rst_ni       (host_rst_ni),
        .req_vld_i         (req_vld_i),
        .req_op_i          (req_op_i),
        .req_cl_i          (req_cl_i),
        .req_data_i        (req_data_i),
        .req_rdy_o         (req_rdy_o),
        .cache_req_vld_o   (cache_req_vld_o),
        .cache_req_op_o    (cache_req_op_o),
        .cache_req_cl_o    (cache_req_cl_o),
        .cache_req_data_o  (cache_req_data_o),
        .emc_busy_i        (emc_busy_i),
        .cache_resp_vld_i  (cache_resp_vld_i),
        .cache_resp_data_i (cache_resp_data_i),
        .cache_resp_exc_i  (cache_resp_exc_i),
        .cache_resp_fwd_i  (cache_resp_fwd_i),
        .resp_vld_o        (resp_vld_o),
        .resp_data_o       (resp_data_o),
        .resp_exc_o        (resp_exc_o),
        .resp_fwd_o        (resp_fwd_o),
        .busy_o            (busy_o),
        .grant_o           (grant_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the channel and how many beats remain.
    int          mOwner    = -1;
    int          mPtr      = 0;
    int          mReqTotal = 0;
    int          mReqLeft  = 0;
    int          mRespLeft = 0;
    int          mWait     = 0;
    logic [1:0]  mOp       = '0;
    logic [22:0] mCl       = '0;

    // Requester side and scenario knobs.
    logic [NREQ-1:0] pend = '0;
    logic [1:0]      pOp   [NREQ];
    logic [22:0]     pCl   [NREQ];
    logic [63:0]     pData [NREQ];
    logic [31:0]     stallMask   = '0;
    bit              stalledBeat = 1'b0;
    bit              respEnable  = 1'b1;
    bit              holdReset   = 1'b0;
    int              strayPct    = 20;
    int              excAt       = -1;
    int              rstAt       = -1;
    int              respSeen    = 0;

    // Observations taken from the DUT for scenario-level checks.
    int              dutRdyCnt  [NREQ];
    int              dutRespCnt [NREQ];
    int              grantLog[$];
    logic [NREQ-1:0] prevGrant = '0;

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < NREQ; i++) begin
            dutRdyCnt[i]  = 0;
            dutRespCnt[i] = 0;
        end
        grantLog.delete();
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] eGrant;
        bit inReq;
        bit inResp;
        bit synth;
        eGrant = (mOwner >= 0) ? NREQ'(1 << mOwner) : '0;
        inReq  = (mOwner >= 0) && (mReqLeft > 0);
        inResp = (mOwner >= 0) && (mReqLeft == 0);
        synth  = 1'b0;
`ifdef HSI_ARB_TIMEOUT_EN
        synth  = inResp && !cache_resp_vld_i && (mWait == 1023);
`endif
        checkValue("busy", busy_o, (mOwner >= 0));
        checkValue("grant", grant_o, eGrant);
        checkValue("cache_req_vld", cache_req_vld_o, inReq);
        checkValue("req_rdy", req_rdy_o, (inReq && !emc_busy_i) ? eGrant : '0);
        checkValue("resp_vld", resp_vld_o,
                   (inResp && (cache_resp_vld_i || synth)) ? eGrant : '0);
        if (inReq) begin
            checkValue("cache_req_op", cache_req_op_o, mOp);
            checkValue("cache_req_cl", cache_req_cl_o, mCl);
            checkValue("cache_req_data", cache_req_data_o, pData[mOwner]);
        end
        if (inResp && cache_resp_vld_i) begin
            checkValue("resp_data", resp_data_o, cache_resp_data_i);
            checkValue("resp_exc", resp_exc_o, cache_resp_exc_i);
            checkValue("resp_fwd", resp_fwd_o, cache_resp_fwd_i);
        end
        if (synth) begin
            checkValue("timeout_data", resp_data_o, 64'd0);
            checkValue("timeout_exc", resp_exc_o, 1'b1);
        end
        for (int i = 0; i < NREQ; i++) begin
            dutRdyCnt[i]  += int'(req_rdy_o[i]);
            dutRespCnt[i] += int'(resp_vld_o[i]);
        end
        if ((grant_o != '0) && (prevGrant == '0)) grantLog.push_back(int'(grant_o));
        prevGrant = grant_o;
    endtask

    task automatic advanceModel();
        int  w;
        bit  found;
        if (!host_rst_ni) begin
            mOwner = -1;
            mPtr   = 0;
            return;
        end
        if (mOwner < 0) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_vld_i[(mPtr + k) % NREQ]) begin
                    w     = (mPtr + k) % NREQ;
                    found = 1'b1;
                end
            end
            if (found) begin
                mOwner    = w;
                mOp       = pOp[w];
                mCl       = pCl[w];
                mReqTotal = (pOp[w] == 2'b11) ? RESP_BEATS : 1;
                mReqLeft  = mReqTotal;
                mRespLeft = (pOp[w] < 2'b10) ? RESP_BEATS : 1;
                mPtr      = (w + 1) % NREQ;
            end
        end else if (mReqLeft > 0) begin
            if (!emc_busy_i) begin
                mReqLeft--;
                if (mReqLeft == 0) mWait = 0;
            end
        end else begin
            if (cache_resp_vld_i) begin
                mRespLeft--;
                mWait = 0;
                if ((mRespLeft == 0) || cache_resp_exc_i) mOwner = -1;
            end
`ifdef HSI_ARB_TIMEOUT_EN
            else if (mWait == 1023) begin
                mOwner = -1;
            end else begin
                mWait++;
            end
`endif
        end
    endtask

    // One clock cycle: drive at the falling edge, check, update the model.
    task automatic applyStimulus();
        bit inReq;
        bit inResp;
        int oldOwner;
        int beatNo;
        inReq    = (mOwner >= 0) && (mReqLeft > 0);
        inResp   = (mOwner >= 0) && (mReqLeft == 0);
        oldOwner = mOwner;

        req_vld_i = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_op_i[2*i +: 2]    = pOp[i];
            req_cl_i[23*i +: 23]  = pCl[i];
            req_data_i[64*i +: 64] = pData[i];
        end
        if (inReq) begin
            beatNo     = mReqTotal - mReqLeft + 1;
            emc_busy_i = stallMask[beatNo] && !stalledBeat;
        end else begin
            emc_busy_i = 1'($urandom_range(0, 1));
        end
        cache_resp_data_i = {$urandom, $urandom};
        cache_resp_fwd_i  = 1'($urandom_range(0, 1));
        if (inResp) begin
            cache_resp_vld_i = respEnable && ($urandom_range(0, 3) != 0);
            cache_resp_exc_i = cache_resp_vld_i && ((respSeen + 1) == excAt);
        end else begin
            cache_resp_vld_i = ($urandom_range(0, 99) < strayPct);
            cache_resp_exc_i = 1'($urandom_range(0, 1));
        end
        host_rst_ni = !holdReset;
        if (inResp && cache_resp_vld_i && (rstAt > 0) && ((respSeen + 1) == rstAt)) begin
            host_rst_ni = 1'b0;
            rstAt       = -1;
        end

        #1;
        checkOutput();
        advanceModel();

        if (!host_rst_ni) begin
            if (oldOwner >= 0) pend[oldOwner] = 1'b0;
        end else if (oldOwner < 0 && mOwner >= 0) begin
            respSeen    = 0;
            stalledBeat = 1'b0;
        end else if (inReq) begin
            if (emc_busy_i) begin
                stalledBeat = 1'b1;
            end else begin
                stalledBeat     = 1'b0;
                pData[oldOwner] = {$urandom, $urandom};
                if (mReqLeft == 0) pend[oldOwner] = 1'b0;
            end
        end else if (inResp && cache_resp_vld_i) begin
            respSeen++;
        end
        @(negedge host_clk_i);
    endtask

    task automatic runTraffic(input string tag, input int budget);
        int n;
        n = 0;
        while (((pend != '0) || (mOwner >= 0)) && (n < budget)) begin
            applyStimulus();
            n++;
        end
        checkValue({tag, "_timeout"}, (n >= budget), 1'b0);
    endtask

    task automatic setReq(input int r, input logic [1:0] op, input logic [22:0] cl);
        pOp[r]   = op;
        pCl[r]   = cl;
        pData[r] = {$urandom, $urandom};
        pend[r]  = 1'b1;
    endtask

    task automatic pulseReset(input int cycles);
        holdReset = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus();
        holdReset = 1'b0;
    endtask

    initial begin
        host_rst_ni       = 1'b0;
        req_vld_i         = '0;
        req_op_i          = '0;
        req_cl_i          = '0;
        req_data_i        = '0;
        emc_busy_i        = 1'b0;
        cache_resp_vld_i  = 1'b0;
        cache_resp_data_i = '0;
        cache_resp_exc_i  = 1'b0;
        cache_resp_fwd_i  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pOp[i]   = '0;
            pCl[i]   = '0;
            pData[i] = '0;
        end
        clearCounts();
        @(negedge host_clk_i);

        $display("[TB] reset state");
        pulseReset(3);
        checkValue("rst_busy", busy_o, 1'b0);
        checkValue("rst_grant", grant_o, '0);

        $display("[TB] requester 0 read of cl 0x000123");
        clearCounts();
        setReq(0, 2'b00, 23'h000123);
        runTraffic("read0", 200);
        checkValue("read0_resp_beats", dutRespCnt[0], RESP_BEATS);
        checkValue("read0_rdy_pulses", dutRdyCnt[0], 1);
        checkValue("read0_busy_after", busy_o, 1'b0);

        $display("[TB] simultaneous requests after reset, round-robin");
        pulseReset(1);
        clearCounts();
        setReq(0, 2'b01, 23'($urandom));
        setReq(1, 2'b10, 23'($urandom));
        runTraffic("rr_a", 300);
        setReq(0, 2'b10, 23'($urandom));
        setReq(1, 2'b00, 23'($urandom));
        runTraffic("rr_b", 300);
        checkValue("rr_count", grantLog.size(), 4);
        if (grantLog.size() >= 3) begin
            checkValue("rr_first", grantLog[0], 1);
            checkValue("rr_second", grantLog[1], 2);
            checkValue("rr_wrap", grantLog[2], 1);
        end

        $display("[TB] requester 1 write-out with stalls on beats 3 and 9");
        clearCounts();
        stallMask = 32'h0000_0208;
        setReq(1, 2'b11, 23'($urandom));
        runTraffic("wrout", 300);
        stallMask = '0;
        checkValue("wrout_rdy_pulses", dutRdyCnt[1], RESP_BEATS);
        checkValue("wrout_resp_beats", dutRespCnt[1], 1);

        $display("[TB] read with exception on response beat 5, then stray beats");
        clearCounts();
        excAt = 5;
        setReq(0, 2'b00, 23'($urandom));
        runTraffic("exc", 300);
        excAt    = -1;
        strayPct = 100;
        for (int i = 0; i < 6; i++) applyStimulus();
        strayPct = 20;
        checkValue("exc_resp_beats", dutRespCnt[0], 5);

        $display("[TB] reset during response beat 7, then fresh arbitration");
        clearCounts();
        rstAt = 7;
        setReq(1, 2'b01, 23'($urandom));
        runTraffic("midrst", 300);
        checkValue("midrst_resp_beats", dutRespCnt[1], 7);
        clearCounts();
        setReq(0, 2'b10, 23'($urandom));
        setReq(1, 2'b11, 23'($urandom));
        runTraffic("postrst", 300);
        checkValue("postrst_count", grantLog.size(), 2);
        if (grantLog.size() >= 1) checkValue("postrst_first", grantLog[0], 1);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 8; r++) begin
            stallMask = $urandom;
            excAt     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : -1;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) setReq(i, 2'($urandom), 23'($urandom));
            end
            runTraffic("random", 600);
        end
        stallMask = '0;
        excAt     = -1;

        $display("[TB] invalidate with no response");
        clearCounts();
        respEnable = 1'b0;
        strayPct   = 0;
        setReq(0, 2'b10, 23'($urandom));
`ifdef HSI_ARB_TIMEOUT_EN
        runTraffic("timeout", 1200);
        checkValue("timeout_beats", dutRespCnt[0], 1);
`else
        for (int i = 0; i < 1100; i++) applyStimulus();
        checkValue("nowdog_still_busy", busy_o, 1'b1);
        checkValue("nowdog_no_resp", dutRespCnt[0], 0);
        respEnable = 1'b1;
        runTraffic("nowdog", 100);
        checkValue("nowdog_resp_beats", dutRespCnt[0], 1);
`endif
        respEnable = 1'b1;
        strayPct   = 20;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
